// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives MAR/RAM/IR/PC controls for one fetch, then hands off to execute.
// Define FETCH_SEQUENCER_TIMEOUT_EN to trap fetches whose memory read never completes.
module fetch_sequencer #(
  parameter logic [5:0]  FETCH_OP       = 6'b000000,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [5:0]  TRAP_CODE      = 6'b000001
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       start,
  input  logic       exec_done,
  input  logic       MFC,
  output logic       MARE,
  output logic [1:0] MAR_SEL,
  output logic       MFA,
  output logic       MOP_SEL,
  output logic [5:0] OP1,
  output logic       MDRE,
  output logic [1:0] MDR_SEL,
  output logic       IRE,
  output logic       PCE,
  output logic       nPCE,
  output logic [1:0] nPC_SEL,
  output logic       nPC_ADD,
  output logic       nPC_ADDSEL,
  output logic       exec_req,
  output logic       tQE,
  output logic [5:0] tQ_IN,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MAR_LD = 3'd1,
    MEM_RD = 3'd2,
    IR_LD  = 3'd3,
    PC_ADV = 3'd4,
    EXEC   = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t cur_state, nxt_state;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) cur_state <= IDLE;
    else      cur_state <= nxt_state;
  end

`ifdef FETCH_SEQUENCER_TIMEOUT_EN
  logic [5:0] wait_cnt;
  logic       timeout;

  // Counter reads zero on the first MEM_RD cycle because it is held clear outside MEM_RD.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)                   wait_cnt <= '0;
    else if (cur_state != MEM_RD) wait_cnt <= '0;
    else if (!MFC)              wait_cnt <= wait_cnt + 6'd1;
  end

  assign timeout = (wait_cnt == 6'(TIMEOUT_CYCLES - 1));
`else
  logic [11:0] unused_cfg;
  assign unused_cfg = {6'(TIMEOUT_CYCLES), TRAP_CODE};
`endif

  always_comb begin
    nxt_state  = IDLE;
    MARE       = 1'b0;
    MAR_SEL    = 2'b00;
    MFA        = 1'b0;
    MOP_SEL    = 1'b0;
    OP1        = 6'b000000;
    MDRE       = 1'b0;
    MDR_SEL    = 2'b00;
    IRE        = 1'b0;
    PCE        = 1'b0;
    nPCE       = 1'b0;
    nPC_SEL    = 2'b00;
    nPC_ADD    = 1'b0;
    nPC_ADDSEL = 1'b0;
    exec_req   = 1'b0;
    tQE        = 1'b0;
    tQ_IN      = 6'b000000;
    busy       = 1'b1;
    case (cur_state)
      IDLE: begin
        busy      = 1'b0;
        nxt_state = start ? MAR_LD : IDLE;
      end
      MAR_LD: begin
        MAR_SEL   = 2'b01;
        MARE      = 1'b1;
        nxt_state = MEM_RD;
      end
      MEM_RD: begin
        MFA       = 1'b1;
        MOP_SEL   = 1'b1;
        OP1       = FETCH_OP;
        MDR_SEL   = 2'b00;
        MDRE      = 1'b1;
        // A completion arriving on the expiry cycle takes priority over the trap.
        if (MFC)          nxt_state = IR_LD;
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
        else if (timeout) nxt_state = TRAP;
`endif
        else              nxt_state = MEM_RD;
      end
      IR_LD: begin
        IRE       = 1'b1;
        nxt_state = PC_ADV;
      end
      PC_ADV: begin
        PCE        = 1'b1;
        nPCE       = 1'b1;
        nPC_SEL    = 2'b00;
        nPC_ADD    = 1'b1;
        nPC_ADDSEL = 1'b0;
        nxt_state  = EXEC;
      end
      EXEC: begin
        exec_req = 1'b1;
        if (!exec_done) nxt_state = EXEC;
        else            nxt_state = start ? MAR_LD : IDLE;
      end
      TRAP: begin
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
        tQE   = 1'b1;
        tQ_IN = TRAP_CODE;
`endif
        nxt_state = IDLE;
      end
      default: begin
        busy      = 1'b0;
        nxt_state = IDLE;
      end
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default parameters).
module tb_fetch_sequencer;

  logic       Clk = 1'b0;
  logic       Clr, start, exec_done, MFC;
  logic       MARE, MFA, MOP_SEL, MDRE, IRE, PCE, nPCE, nPC_ADD, nPC_ADDSEL;
  logic       exec_req, tQE, busy;
  logic [1:0] MAR_SEL, MDR_SEL, nPC_SEL;
  logic [5:0] OP1, tQ_IN;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .Clk(Clk), .Clr(Clr), .start(start), .exec_done(exec_done), .MFC(MFC),
    .MARE(MARE), .MAR_SEL(MAR_SEL), .MFA(MFA), .MOP_SEL(MOP_SEL), .OP1(OP1),
    .MDRE(MDRE), .MDR_SEL(MDR_SEL), .IRE(IRE), .PCE(PCE), .nPCE(nPCE),
    .nPC_SEL(nPC_SEL), .nPC_ADD(nPC_ADD), .nPC_ADDSEL(nPC_ADDSEL),
    .exec_req(exec_req), .tQE(tQE), .tQ_IN(tQ_IN), .busy(busy), .state(state)
  );

  always #5 Clk = ~Clk;

  function automatic logic [32:0] allOuts();
    return {MARE, MAR_SEL, MFA, MOP_SEL, OP1, MDRE, MDR_SEL, IRE, PCE, nPCE,
            nPC_SEL, nPC_ADD, nPC_ADDSEL, exec_req, tQE, tQ_IN, busy, state};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge Clk);
    #1;
  endtask

  int memCycles, mfaCycles, mdreCycles, ireCycles, pceCycles, pcePair;
  logic stuckOk, tqeSeen;

  initial begin
    Clr = 1'b0; start = 1'b1; MFC = 1'b1; exec_done = 1'b0;

    // Reset held with start asserted: nothing moves
    repeat (3) applyStimulus();
    checkOutput("reset_all_zero", 64'(allOuts()), 64'd0);

    // Minimum-latency fetch
    Clr = 1'b1;
    applyStimulus();
    checkOutput("marld_state", 64'(state), 64'd1);
    checkOutput("marld_ctl", 64'({MARE, MAR_SEL}), 64'(3'b101));
    applyStimulus();
    checkOutput("memrd_state", 64'(state), 64'd2);
    checkOutput("memrd_ctl", 64'({MFA, MOP_SEL, MDRE, MDR_SEL, OP1}), 64'(11'b111_00_000000));
    applyStimulus();
    checkOutput("irld_state", 64'(state), 64'd3);
    checkOutput("irld_ctl", 64'({IRE, MFA}), 64'(2'b10));
    applyStimulus();
    checkOutput("pcadv_state", 64'(state), 64'd4);
    checkOutput("pcadv_ctl", 64'({PCE, nPCE, nPC_SEL, nPC_ADD, nPC_ADDSEL}), 64'(6'b110010));
    applyStimulus();
    checkOutput("exec_state", 64'(state), 64'd5);
    checkOutput("exec_req_busy", 64'({exec_req, busy}), 64'(2'b11));

    // exec_req held until exec_done, then back-to-back fetch
    applyStimulus();
    applyStimulus();
    checkOutput("exec_hold", 64'({state, exec_req}), 64'({3'd5, 1'b1}));
    exec_done = 1'b1;
    applyStimulus();
    checkOutput("b2b_fetch", 64'(state), 64'd1);

    // MFC delayed 4 cycles, start dropped and exec_done high throughout
    start = 1'b0; MFC = 1'b0;
    memCycles = 0; mfaCycles = 0; mdreCycles = 0; ireCycles = 0; pceCycles = 0; pcePair = 0;
    for (int i = 0; i < 12; i++) begin
      MFC = (memCycles >= 5);
      applyStimulus();
      if (state == 3'd2) memCycles++;
      if (MFA) mfaCycles++;
      if (MDRE) mdreCycles++;
      if (IRE) ireCycles++;
      if (PCE) pceCycles++;
      if (PCE && nPCE) pcePair++;
    end
    checkOutput("slow_mfa", 64'(mfaCycles), 64'd5);
    checkOutput("slow_mdre", 64'(mdreCycles), 64'd5);
    checkOutput("slow_ire", 64'(ireCycles), 64'd1);
    checkOutput("slow_pce", 64'(pceCycles), 64'd1);
    checkOutput("slow_pce_npce", 64'(pcePair), 64'd1);
    checkOutput("slow_end_idle", 64'({state, busy}), 64'({3'd0, 1'b0}));

    // Asynchronous reset in the middle of MEM_RD
    exec_done = 1'b0; start = 1'b1; MFC = 1'b0;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    checkOutput("pre_clr_mfa", 64'({state, MFA}), 64'({3'd2, 1'b1}));
    #2 Clr = 1'b0;
    #1 checkOutput("async_clr", 64'(allOuts()), 64'd0);
    @(negedge Clk);
    Clr = 1'b1;
    applyStimulus();
    checkOutput("idle_no_start", 64'(state), 64'd0);
    start = 1'b1;
    applyStimulus();
    checkOutput("restart", 64'(state), 64'd1);
    start = 1'b0;

`ifdef FETCH_SEQUENCER_TIMEOUT_EN
    // Timeout expiry traps after 15 MEM_RD cycles
    applyStimulus();
    memCycles = 1;
    for (int i = 0; i < 20 && state == 3'd2; i++) begin
      applyStimulus();
      if (state == 3'd2) memCycles++;
    end
    checkOutput("to_memrd_cycles", 64'(memCycles), 64'd15);
    checkOutput("to_trap", 64'({state, tQE, tQ_IN}), 64'({3'd6, 1'b1, 6'b000001}));
    applyStimulus();
    checkOutput("to_trap_one_cycle", 64'({state, tQE}), 64'({3'd0, 1'b0}));

    // MFC arriving on the expiry cycle wins
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    stuckOk = 1'b1;
    for (int c = 1; c < 15; c++) begin
      applyStimulus();
      if (state != 3'd2) stuckOk = 1'b0;
    end
    checkOutput("race_waiting", 64'(stuckOk), 64'd1);
    MFC = 1'b1;
    applyStimulus();
    checkOutput("race_mfc_wins", 64'({state, tQE}), 64'({3'd3, 1'b0}));
    MFC = 1'b0;
    applyStimulus();
    applyStimulus();
    exec_done = 1'b1;
    applyStimulus();
    checkOutput("race_done_idle", 64'(state), 64'd0);
    exec_done = 1'b0;
`else
    // Without the timeout, MEM_RD waits indefinitely
    applyStimulus();
    stuckOk = 1'b1; tqeSeen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus();
      if (state != 3'd2) stuckOk = 1'b0;
      if (tQE !== 1'b0) tqeSeen = 1'b1;
    end
    checkOutput("wait_forever", 64'(stuckOk), 64'd1);
    checkOutput("no_trap", 64'(tqeSeen), 64'd0);
    Clr = 1'b0;
    applyStimulus();
    checkOutput("clr_from_wait", 64'(allOuts()), 64'd0);
    Clr = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
